// File: rtl/fpu_pkg.sv
// fpu_pkg: shared op encoding, ftoi constants and the leading-zero helper for the fcvt unit.
// Used by fcvt_core (datapath) and fcvt_arb (top). Optional itof support is FCVT_ITOF_EN.
package fpu_pkg;

   typedef enum logic {
      FCVT_FTOI = 1'b0,
      FCVT_ITOF = 1'b1
   } fcvt_op_e;

   localparam int unsigned FTOI_BIAS_TOP = 157;
   localparam logic [31:0] FTOI_SAT_POS  = 32'h7FFFFFFF;
   localparam logic [31:0] FTOI_SAT_NEG  = 32'h80000000;

   // Leading zeros of a non-zero word; the zero case is flagged separately by the caller.
   function automatic logic [4:0] lzc32(input logic [31:0] v);
      lzc32 = 5'd31;
      for (int i = 0; i < 32; i++)
         if (v[i]) lzc32 = 5'(31 - i);
   endfunction

endpackage

// File: rtl/fcvt_core.sv
// fcvt_core: two-stage float<->int32 conversion datapath (ftoi truncate, optional itof RNE).
// Ports: clk, rstn (async active-low); s1_en loads stage 1, s2_en loads stage 2;
//        in_fire/in_op/in_x/in_tag/in_src describe the accepted op;
//        s1_valid/s2_valid report occupancy; out_y/out_tag/out_src are the stage-2 result.
// Macro FCVT_ITOF_EN adds the itof path; without it op=1 yields 0 but keeps tag/src.
module fcvt_core
   import fpu_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             s1_en,
   input  logic             s2_en,
   input  logic             in_fire,
   input  logic             in_op,
   input  logic [31:0]      in_x,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_src,
   output logic             s1_valid,
   output logic             s2_valid,
   output logic [31:0]      out_y,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_src
);

   logic [7:0]       e;
   fcvt_op_e         s1_op;
   logic [TAG_W-1:0] s1_tag;
   logic             s1_src;
   logic             s1_sign;
   logic [30:0]      s1_mant;
   logic [4:0]       s1_sh;
   logic             s1_small;
   logic             s1_sat;
   logic [30:0]      ftoi_mag;
   logic [31:0]      ftoi_y;
   logic [31:0]      y_next;

   assign e = in_x[30:23];

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) s1_valid <= 1'b0;
      else if (s1_en) s1_valid <= in_fire;

   always_ff @(posedge clk)
      if (s1_en && in_fire) begin
         s1_op    <= fcvt_op_e'(in_op);
         s1_tag   <= in_tag;
         s1_src   <= in_src;
         s1_sign  <= in_x[31];
         s1_mant  <= {1'b1, in_x[22:0], 7'b0};
         // Only meaningful for 127..157, where it lands in 0..30.
         s1_sh    <= 5'(8'(FTOI_BIAS_TOP) - e);
         s1_small <= e < 8'd127;
         s1_sat   <= e > 8'(FTOI_BIAS_TOP);
      end

   assign ftoi_mag = s1_mant >> s1_sh;
   assign ftoi_y   = s1_small ? 32'd0 :
                     s1_sat   ? (s1_sign ? FTOI_SAT_NEG : FTOI_SAT_POS) :
                     s1_sign  ? -{1'b0, ftoi_mag} : {1'b0, ftoi_mag};

`ifdef FCVT_ITOF_EN
   logic [31:0] mag_in;
   logic [31:0] s1_mag;
   logic [4:0]  s1_lz;
   logic        s1_izero;
   logic [31:0] norm;
   logic        up;
   logic [31:0] itof_y;

   assign mag_in = in_x[31] ? -in_x : in_x;

   always_ff @(posedge clk)
      if (s1_en && in_fire) begin
         s1_mag   <= mag_in;
         s1_lz    <= lzc32(mag_in);
         s1_izero <= in_x == 32'd0;
      end

   assign norm = s1_mag << s1_lz;
   assign up   = norm[7] & ((|norm[6:0]) | norm[8]);
   // The hidden bit norm[31] adds the final +1 to the exponent field (157-lz+1 = 158-lz);
   // a rounding carry out of the fraction likewise bumps the exponent.
   assign itof_y = s1_izero ? 32'd0 :
                   {s1_sign, 8'd157 - {3'b0, s1_lz}, 23'b0} + {8'b0, norm[31:8]} + {31'b0, up};
   assign y_next = (s1_op == FCVT_ITOF) ? itof_y : ftoi_y;
`else
   assign y_next = (s1_op == FCVT_ITOF) ? 32'd0 : ftoi_y;
`endif

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         s2_valid <= 1'b0;
         out_y    <= '0;
         out_tag  <= '0;
         out_src  <= 1'b0;
      end else if (s2_en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_y   <= y_next;
            out_tag <= s1_tag;
            out_src <= s1_src;
         end
      end

endmodule

// File: rtl/fcvt_arb.sv
// fcvt_arb: two-requester round-robin front end for a shared 2-stage float/int converter.
// Ports: clk, rstn (async active-low); req_valid/req_ready/req_op/req_x/req_tag per requester;
//        out_valid/out_ready/out_y/out_tag/out_src result port; inflight = ops in the pipe (0-2).
// Macro FCVT_ITOF_EN enables int32->float for op=1 (otherwise op=1 returns 0).
module fcvt_arb
   import fpu_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0]            req_op,
   input  logic [1:0][31:0]      req_x,
   input  logic [1:0][TAG_W-1:0] req_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_y,
   output logic [TAG_W-1:0]      out_tag,
   output logic                  out_src,
   output logic [1:0]            inflight
);

   logic       rr;
   logic [1:0] grant;
   logic       s1_valid;
   logic       s2_valid;
   logic       s1_adv;
   logic       adv;
   logic       fire;
   logic       src;

   assign s1_adv    = !s2_valid | out_ready;
   assign adv       = !s1_valid | s1_adv;
   assign grant[0]  = req_valid[0] & (!req_valid[1] | !rr);
   assign grant[1]  = req_valid[1] & (!req_valid[0] | rr);
   // rstn gating keeps ready low throughout reset even though the pipe looks empty.
   assign req_ready = grant & {2{adv & rstn}};
   assign fire      = |(req_valid & req_ready);
   assign src       = req_ready[1];
   assign out_valid = s2_valid;
   assign inflight  = {1'b0, s1_valid} + {1'b0, s2_valid};

   always_ff @(posedge clk or negedge rstn)
      if (!rstn) rr <= 1'b0;
      else if (fire) rr <= !src;

   fcvt_core #(.TAG_W(TAG_W)) u_core (
      .clk      (clk),
      .rstn     (rstn),
      .s1_en    (adv),
      .s2_en    (s1_adv),
      .in_fire  (fire),
      .in_op    (req_op[src]),
      .in_x     (req_x[src]),
      .in_tag   (req_tag[src]),
      .in_src   (src),
      .s1_valid (s1_valid),
      .s2_valid (s2_valid),
      .out_y    (out_y),
      .out_tag  (out_tag),
      .out_src  (out_src)
   );

endmodule
